// File: rtl/sm3_pkg.sv
// Shared SM3 constants, state encoding and the XOR/rotate helpers
// used by message expansion and compression.
package sm3_pkg;
  localparam int SM3_WORD_W     = 32;
  localparam int SM3_NUM_ROUNDS = 64;
  localparam int SM3_BLK_WORDS  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2
  } sm3_state_t;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl32(x, 15) ^ rotl32(x, 23);
  endfunction
endpackage

// File: rtl/sm3_w_next.sv
// Combinational SM3 expansion step: W_{j+16} from the taps of a
// window holding W_j..W_{j+15}.
module sm3_w_next
  import sm3_pkg::*;
(
  input  logic [31:0] i_w0,
  input  logic [31:0] i_w3,
  input  logic [31:0] i_w7,
  input  logic [31:0] i_w10,
  input  logic [31:0] i_w13,
  output logic [31:0] o_w16
);
  logic [31:0] w_mix;

  assign w_mix = i_w0 ^ i_w7 ^ rotl32(i_w13, 15);
  assign o_w16 = p1(w_mix) ^ rotl32(i_w3, 7) ^ i_w10;
endmodule

// File: rtl/sm3_msg_expander.sv
// SM3 message expander: loads 16 words of a block, then streams
// W_j / W'_j for j = 0..63 from a 16-word sliding window.
module sm3_msg_expander
  import sm3_pkg::*;
#(
  parameter int NUM_ROUNDS = 64,
  parameter int WORD_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [WORD_W-1:0] out_w,
  output logic [WORD_W-1:0] out_wp,
  output logic [5:0]        out_idx,
  output logic              out_last,
  output logic              busy
);
  if (NUM_ROUNDS != SM3_NUM_ROUNDS) begin : g_bad_rounds
    $error("sm3_msg_expander: only NUM_ROUNDS=64 is supported");
  end
  if (WORD_W != SM3_WORD_W) begin : g_bad_width
    $error("sm3_msg_expander: only WORD_W=32 is supported");
  end

  localparam logic [5:0] LAST_IDX  = 6'(SM3_NUM_ROUNDS - 1);
  localparam logic [3:0] LAST_LOAD = 4'(SM3_BLK_WORDS - 1);

  sm3_state_t        r_state;
  logic [WORD_W-1:0] r_win [SM3_BLK_WORDS];
  logic [3:0]        r_load_cnt;
  logic [5:0]        r_round_cnt;
  logic              r_in_rdy;
  logic              r_out_vld;
  logic              r_busy;
  logic              w_in_hs;
  logic              w_out_hs;
  logic [WORD_W-1:0] w_next;

  sm3_w_next u_w_next (
    .i_w0  (r_win[0]),
    .i_w3  (r_win[3]),
    .i_w7  (r_win[7]),
    .i_w10 (r_win[10]),
    .i_w13 (r_win[13]),
    .o_w16 (w_next)
  );

  assign w_in_hs  = in_vld & r_in_rdy;
  assign w_out_hs = r_out_vld & out_rdy;

  assign in_rdy   = r_in_rdy;
  assign out_vld  = r_out_vld;
  assign busy     = r_busy;
  assign out_w    = r_win[0];
  assign out_wp   = r_win[0] ^ r_win[4];
  assign out_idx  = r_round_cnt;
  assign out_last = (r_round_cnt == LAST_IDX);

  // Handshake flags are registered alongside the state so they always
  // reflect the state the FSM is in, and read 0 while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_load_cnt  <= '0;
      r_round_cnt <= '0;
      r_in_rdy    <= 1'b0;
      r_out_vld   <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < SM3_BLK_WORDS; i++) r_win[i] <= '0;
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_load_cnt  <= '0;
      r_round_cnt <= '0;
      r_in_rdy    <= 1'b1;
      r_out_vld   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          r_in_rdy <= 1'b1;
          if (w_in_hs) begin
            for (int i = 0; i < SM3_BLK_WORDS - 1; i++) r_win[i] <= r_win[i+1];
            r_win[SM3_BLK_WORDS-1] <= in_word;
            r_busy <= 1'b1;
            if (r_load_cnt == LAST_LOAD) begin
              r_state    <= ST_EXPAND;
              r_load_cnt <= '0;
              r_in_rdy   <= 1'b0;
              r_out_vld  <= 1'b1;
            end else begin
              r_state    <= ST_LOAD;
              r_load_cnt <= r_load_cnt + 4'd1;
            end
          end
        end
        ST_EXPAND: begin
          if (w_out_hs) begin
            for (int i = 0; i < SM3_BLK_WORDS - 1; i++) r_win[i] <= r_win[i+1];
            r_win[SM3_BLK_WORDS-1] <= w_next;
            if (r_round_cnt == LAST_IDX) begin
              r_state     <= ST_IDLE;
              r_round_cnt <= '0;
              r_out_vld   <= 1'b0;
              r_in_rdy    <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_round_cnt <= r_round_cnt + 6'd1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_in_rdy  <= 1'b1;
          r_out_vld <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule
